// File: rtl/bolme_birimi_if.sv
// Pipeline <-> divider bus for the YURUT stage: op request, stall input, result and ready.
interface bolme_birimi_if;
  logic        basla_i;
  logic [1:0]  islem_i;
  logic [31:0] bolunen_i;
  logic [31:0] bolen_i;
  logic        durdur_i;
  logic [31:0] sonuc_o;
  logic        hazir_o;

  modport master (
    output basla_i, islem_i, bolunen_i, bolen_i, durdur_i,
    input  sonuc_o, hazir_o
  );

  modport slave (
    input  basla_i, islem_i, bolunen_i, bolen_i, durdur_i,
    output sonuc_o, hazir_o
  );
endinterface

// File: rtl/bolme_birimi.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the YURUT stage.
// Latency: 33 stall cycles for a normal op, 1 for divide-by-zero / signed overflow.
// Backpressure: holds the finished result in BITTI while durdur_i=1; basla_i=0 aborts.
module bolme_birimi (
  input  logic          clk_i,
  input  logic          rst_i,
  bolme_birimi_if.slave bus
);

  typedef enum logic [1:0] {
    BOS     = 2'd0,
    HESAPLA = 2'd1,
    BITTI   = 2'd2
  } durum_t;

  durum_t      durum, durum_d;
  logic [31:0] kalan, kalan_d;
  logic [31:0] bolum, bolum_d;
  logic [31:0] bolen_r, bolen_d;
  logic [31:0] sonuc_r, sonuc_d;
  logic [4:0]  sayac, sayac_d;
  logic        bolum_neg, bolum_neg_d;
  logic        kalan_neg, kalan_neg_d;
  logic        kalan_sec, kalan_sec_d;

  logic        isaretli, kalan_istek, sifir_bolen, tasma;
  logic [31:0] mutlak_bolunen, mutlak_bolen;
  logic [32:0] deneme, fark;
  logic [31:0] adim_kalan, adim_bolum, son_kalan, son_bolum;

  always_comb begin : giris_cozumle
    isaretli       = ~bus.islem_i[0];
    kalan_istek    = bus.islem_i[1];
    sifir_bolen    = (bus.bolen_i == 32'h0000_0000);
    tasma          = isaretli && (bus.bolunen_i == 32'h8000_0000) &&
                     (bus.bolen_i == 32'hFFFF_FFFF);
    mutlak_bolunen = (isaretli && bus.bolunen_i[31]) ? -bus.bolunen_i : bus.bolunen_i;
    mutlak_bolen   = (isaretli && bus.bolen_i[31])   ? -bus.bolen_i   : bus.bolen_i;
  end

  // The partial remainder stays below the divisor, so after the shift it needs
  // 33 bits and the difference, when non-negative, always fits back into 32.
  always_comb begin : adim
    deneme = {kalan, bolum[31]};
    fark   = deneme - {1'b0, bolen_r};
    if (!fark[32]) begin
      adim_kalan = fark[31:0];
      adim_bolum = {bolum[30:0], 1'b1};
    end else begin
      adim_kalan = deneme[31:0];
      adim_bolum = {bolum[30:0], 1'b0};
    end
    son_bolum = bolum_neg ? -adim_bolum : adim_bolum;
    son_kalan = kalan_neg ? -adim_kalan : adim_kalan;
  end

  always_comb begin : durum_gecis
    durum_d     = durum;
    kalan_d     = kalan;
    bolum_d     = bolum;
    bolen_d     = bolen_r;
    sonuc_d     = sonuc_r;
    sayac_d     = sayac;
    bolum_neg_d = bolum_neg;
    kalan_neg_d = kalan_neg;
    kalan_sec_d = kalan_sec;
    bus.hazir_o = 1'b0;

    case (durum)
      BOS: begin
        bus.hazir_o = ~bus.basla_i;
        if (bus.basla_i) begin
          kalan_sec_d = kalan_istek;
          if (sifir_bolen) begin
            sonuc_d = kalan_istek ? bus.bolunen_i : 32'hFFFF_FFFF;
            durum_d = BITTI;
          end else if (tasma) begin
            sonuc_d = kalan_istek ? 32'h0000_0000 : 32'h8000_0000;
            durum_d = BITTI;
          end else begin
            kalan_d     = 32'h0000_0000;
            bolum_d     = mutlak_bolunen;
            bolen_d     = mutlak_bolen;
            sayac_d     = 5'd0;
            bolum_neg_d = isaretli & (bus.bolunen_i[31] ^ bus.bolen_i[31]);
            kalan_neg_d = isaretli & bus.bolunen_i[31];
            durum_d     = HESAPLA;
          end
        end
      end

      HESAPLA: begin
        if (!bus.basla_i) begin
          durum_d = BOS;
        end else begin
          kalan_d = adim_kalan;
          bolum_d = adim_bolum;
          sayac_d = sayac + 5'd1;
          if (sayac == 5'd31) begin
            sonuc_d = kalan_sec ? son_kalan : son_bolum;
            durum_d = BITTI;
          end
        end
      end

      BITTI: begin
        bus.hazir_o = 1'b1;
        if (!bus.basla_i || !bus.durdur_i) durum_d = BOS;
      end

      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum     <= BOS;
      kalan     <= '0;
      bolum     <= '0;
      bolen_r   <= '0;
      sonuc_r   <= '0;
      sayac     <= '0;
      bolum_neg <= 1'b0;
      kalan_neg <= 1'b0;
      kalan_sec <= 1'b0;
    end else begin
      durum     <= durum_d;
      kalan     <= kalan_d;
      bolum     <= bolum_d;
      bolen_r   <= bolen_d;
      sonuc_r   <= sonuc_d;
      sayac     <= sayac_d;
      bolum_neg <= bolum_neg_d;
      kalan_neg <= kalan_neg_d;
      kalan_sec <= kalan_sec_d;
    end
  end

  assign bus.sonuc_o = sonuc_r;

endmodule

// File: tb/tb_bolme_birimi.sv
// Bench for bolme_birimi: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_bolme_birimi;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bolme_birimi_if bus ();

  bolme_birimi dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beklenen(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int gecikme(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cevrim;
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at the beginning of a cycle (1 time unit after the rising edge).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input bit keep);
    logic [31:0] exp;
    int lat;
    int n;
    exp = beklenen(op, a, b);
    lat = gecikme(op, a, b);
    n   = 0;
    bus.basla_i   = 1'b1;
    bus.islem_i   = op;
    bus.bolunen_i = a;
    bus.bolen_i   = b;
    bus.durdur_i  = (stall > 0);
    @(negedge clk);
    while (bus.hazir_o === 1'b0 && n < 100) begin
      n++;
      cevrim();
      if (n == 1) begin
        bus.islem_i   = 2'($urandom_range(0, 3));
        bus.bolunen_i = $urandom;
        bus.bolen_i   = $urandom;
      end
      @(negedge clk);
    end
    chk({tag, "/stall_cycles"}, 32'(n), 32'(lat));
    for (int k = 0; k <= stall; k++) begin
      chk({tag, "/hazir"}, {31'b0, bus.hazir_o}, 32'd1);
      chk({tag, "/sonuc"}, bus.sonuc_o, exp);
      cevrim();
      bus.durdur_i = (k + 1 < stall);
      if (k < stall) @(negedge clk);
    end
    if (!keep) begin
      bus.basla_i = 1'b0;
      @(negedge clk);
      chk({tag, "/idle_hazir"}, {31'b0, bus.hazir_o}, 32'd1);
      cevrim();
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          kind;

    rst           = 1'b1;
    bus.basla_i   = 1'b0;
    bus.islem_i   = 2'b00;
    bus.bolunen_i = '0;
    bus.bolen_i   = '0;
    bus.durdur_i  = 1'b0;
    repeat (2) cevrim();
    @(negedge clk);
    chk("reset/sonuc", bus.sonuc_o, 32'h0);
    chk("reset/hazir", {31'b0, bus.hazir_o}, 32'd1);
    cevrim();
    rst = 1'b0;
    cevrim();

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 0);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("remu_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0, 0, 0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 0, 0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_ovf_operands", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_stall3", 2'b01, 32'd100, 32'd7, 3, 0);
    run_op("b2b_first",  2'b01, 32'd100, 32'd7, 0, 1);
    run_op("b2b_second", 2'b01, 32'd9, 32'd3, 0, 0);

    // Reset in the middle of a DIV: result register must clear, no partial value.
    bus.basla_i   = 1'b1;
    bus.islem_i   = 2'b00;
    bus.bolunen_i = 32'hFFFF_FF9C;
    bus.bolen_i   = 32'd7;
    repeat (10) cevrim();
    rst = 1'b1;
    cevrim();
    rst = 1'b0;
    bus.basla_i = 1'b0;
    @(negedge clk);
    chk("midreset/sonuc", bus.sonuc_o, 32'h0);
    chk("midreset/hazir", {31'b0, bus.hazir_o}, 32'd1);
    cevrim();
    run_op("after_reset", 2'b00, 32'hFFFF_FF9C, 32'd7, 0, 0);

    // Flush: basla_i dropped mid-computation.
    bus.basla_i   = 1'b1;
    bus.islem_i   = 2'b00;
    bus.bolunen_i = 32'd1000;
    bus.bolen_i   = 32'd13;
    repeat (10) cevrim();
    bus.basla_i = 1'b0;
    @(negedge clk);
    chk("abort/busy_same_cycle", {31'b0, bus.hazir_o}, 32'd0);
    cevrim();
    @(negedge clk);
    chk("abort/hazir_next", {31'b0, bus.hazir_o}, 32'd1);
    cevrim();
    run_op("after_abort", 2'b10, 32'd1000, 32'd13, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (kind == 0) b = 32'h0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind <= 4) b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, $urandom_range(0, 2),
             (i != 39) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
